// File: rtl/move_board.sv
// Cursor-and-mark controller for a 4x4 two-player board: edge-detected move/select
// buttons drive a wrapping cursor and alternate player marks into 16 two-bit cells.
module move_board (
  input  logic       clk,
  input  logic       rst,
  input  logic       move,
  input  logic       select,
  output logic [3:0] c1,
  output logic [3:0] c2,
  output logic [3:0] c3,
  output logic [3:0] c4,
  output logic [3:0] c5,
  output logic [3:0] c6,
  output logic [3:0] c7,
  output logic [3:0] c8,
  output logic [3:0] c9,
  output logic [3:0] c10,
  output logic [3:0] c11,
  output logic [3:0] c12,
  output logic [3:0] c13,
  output logic [3:0] c14,
  output logic [3:0] c15,
  output logic [3:0] c16,
  output logic [7:0] counter
);

  localparam logic [1:0] CELL_EMPTY = 2'd0;
  localparam logic [1:0] CELL_P1    = 2'd1;
  localparam logic [1:0] CELL_P2    = 2'd2;

  logic [1:0] cells [16];
  logic [3:0] cursor;
  logic       player;
  logic       prev_move;
  logic       prev_select;
  logic       move_evt;
  logic       select_evt;
  logic [3:0] code [16];

  assign move_evt   = move & ~prev_move;
  assign select_evt = select & ~prev_select;

  // NOTE: state registers use non-blocking assignments so every update in this
  // block sees the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the cell array is plain flops, not a RAM, so clearing it on reset is
      // cheap and required for a known starting board.
      for (int k = 0; k < 16; k++) cells[k] <= CELL_EMPTY;
      cursor      <= 4'd0;
      player      <= 1'b0;
      prev_move   <= 1'b0;
      prev_select <= 1'b0;
    end else begin
      prev_move   <= move;
      prev_select <= select;
      // Select has priority; a simultaneous move is dropped.
      if (select_evt) begin
        if (cells[cursor] == CELL_EMPTY) begin
          cells[cursor] <= player ? CELL_P2 : CELL_P1;
          player        <= ~player;
        end
      end else if (move_evt) begin
        cursor <= cursor + 4'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++) code[k] = {cursor == 4'(k), 1'b0, cells[k]};
  end

  assign c1  = code[0];
  assign c2  = code[1];
  assign c3  = code[2];
  assign c4  = code[3];
  assign c5  = code[4];
  assign c6  = code[5];
  assign c7  = code[6];
  assign c8  = code[7];
  assign c9  = code[8];
  assign c10 = code[9];
  assign c11 = code[10];
  assign c12 = code[11];
  assign c13 = code[12];
  assign c14 = code[13];
  assign c15 = code[14];
  assign c16 = code[15];

  assign counter = {4'd0, cursor};

endmodule

// File: tb/tb_move_board.sv
// Directed self-checking bench for move_board: reset, cursor wrap, marking,
// held levels, simultaneous events and mid-game reset.
module tb_move_board;

  logic       clk = 1'b0;
  logic       rst;
  logic       move;
  logic       select;
  logic [3:0] c [16];
  logic [7:0] counter;

  int errors = 0;
  int checks = 0;

  // Hand-maintained expected board: cell values 0/1/2 and cursor index.
  logic [1:0] exp_cells [16];
  logic [3:0] exp_cursor;

  always #5 clk = ~clk;

  move_board dut (
    .clk(clk), .rst(rst), .move(move), .select(select),
    .c1(c[0]),   .c2(c[1]),   .c3(c[2]),   .c4(c[3]),
    .c5(c[4]),   .c6(c[5]),   .c7(c[6]),   .c8(c[7]),
    .c9(c[8]),   .c10(c[9]),  .c11(c[10]), .c12(c[11]),
    .c13(c[12]), .c14(c[13]), .c15(c[14]), .c16(c[15]),
    .counter(counter)
  );

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_board(input string tag);
    logic [3:0] e;
    for (int k = 0; k < 16; k++) begin
      e = {exp_cursor == 4'(k), 1'b0, exp_cells[k]};
      check($sformatf("%s c%0d", tag, k + 1), {4'd0, c[k]}, {4'd0, e});
    end
    check({tag, " counter"}, counter, {4'd0, exp_cursor});
  endtask

  task automatic clear_model();
    for (int k = 0; k < 16; k++) exp_cells[k] = 2'd0;
    exp_cursor = 4'd0;
  endtask

  task automatic pulse_move();
    move = 1'b1; tick();
    move = 1'b0; tick();
  endtask

  task automatic pulse_select();
    select = 1'b1; tick();
    select = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b1; move = 1'b0; select = 1'b0;
    clear_model();

    // 1. Reset then idle
    tick(); tick();
    rst = 1'b0;
    check("reset c1", {4'd0, c[0]}, 8'h08);
    check_board("reset");
    repeat (5) tick();
    check_board("idle");

    // 2. Cursor wrap over 16 pulses
    for (int i = 1; i <= 16; i++) begin
      move = 1'b1; tick();
      check($sformatf("wrap step %0d", i), counter, 8'((i) % 16));
      if (i == 1) begin
        check("wrap p1 c1", {4'd0, c[0]}, 8'h00);
        check("wrap p1 c2", {4'd0, c[1]}, 8'h08);
      end
      if (i == 16) check("wrap p16 c1", {4'd0, c[0]}, 8'h08);
      move = 1'b0; tick();
    end

    // 3. Alternating marks
    pulse_move();
    pulse_select();
    check("mark p1 c2 under cursor", {4'd0, c[1]}, 8'h09);
    repeat (8) pulse_move();
    pulse_select();
    check("mark p2 c10", {4'd0, c[9]}, 8'h0A);
    check("mark p2 counter", counter, 8'd9);
    check("mark p1 c2", {4'd0, c[1]}, 8'h01);
    pulse_select();
    check("occupied c10 kept", {4'd0, c[9]}, 8'h0A);
    pulse_move();
    pulse_select();
    // Occupied select did not toggle: player 1 marks cell 10.
    check("mark c11 player1", {4'd0, c[10]}, 8'h09);
    pulse_move();
    pulse_select();
    check("mark c12 player2", {4'd0, c[11]}, 8'h0A);
    exp_cells[1] = 2'd1; exp_cells[9] = 2'd2; exp_cells[10] = 2'd1; exp_cells[11] = 2'd2;
    exp_cursor = 4'd11;
    check_board("after marks");

    // 6. Reset mid-game with move (and select) held high
    move = 1'b1; select = 1'b1; rst = 1'b1;
    tick();
    clear_model();
    check_board("midreset");
    tick();
    check_board("midreset held");
    select = 1'b0; rst = 1'b0;
    tick();
    check("post-reset move advance", counter, 8'd1);
    tick();
    check("post-reset single advance", counter, 8'd1);
    move = 1'b0; tick();
    pulse_select();
    check("post-reset mark player1", {4'd0, c[1]}, 8'h09);

    // 4. Held select on empty cell, then held move
    pulse_move();
    select = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("held select %0d", i), {4'd0, c[2]}, 8'h0A);
    end
    select = 1'b0; tick();
    move = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("held move %0d", i), counter, 8'd3);
    end
    move = 1'b0; tick();

    // 5. Simultaneous move+select at cursor 3: player 1 marks, cursor holds
    move = 1'b1; select = 1'b1;
    tick();
    check("simul c4", {4'd0, c[3]}, 8'h09);
    check("simul counter", counter, 8'd3);
    move = 1'b0; select = 1'b0; tick();
    exp_cells[1] = 2'd1; exp_cells[2] = 2'd2; exp_cells[3] = 2'd1;
    exp_cursor = 4'd3;
    check_board("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
